bram_tile_loader: RTL
=====================

Name: bram_tile_loader

Overview:
Parametrised streaming successor to the fixed 4x4 tile burst loader. Reads a TILE_ROWS x TILE_COLS sub-matrix from the row-major global BRAM, one element per cycle, with configurable read latency. Packs each tile row into TILE_COLS parallel lanes and writes it to the lane tile BRAMs as soon as that row is complete, into the ping-pong half chosen at start. Sits between the global weight/activation BRAM and the LSTM MAC tile buffers.

Parameters:
DATA_WIDTH, 32, element width
ADDR_WIDTH, 10, global and tile address width
MATRIX_COLS, 8, row stride of the source matrix, in elements
TILE_ROWS, 4, rows per tile (>=1)
TILE_COLS, 4, columns per tile = number of write lanes (>=1)
RD_LATENCY, 1, global BRAM read latency in cycles (1 or 2)
ALMOST_LEFT, 3, elements remaining when almost_full_pulse fires (< TILE_ROWS*TILE_COLS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a tile load; sampled only in IDLE
base_addr  in  ADDR_WIDTH  global address of tile element (0,0); latched on accept
buf_sel  in  1  ping-pong half; latched on accept
busy  out  1  high from the cycle after accept through the done cycle
done  out  1  one-cycle completion pulse
global_addr  out  ADDR_WIDTH  global read address
global_re  out  1  global read enable
global_dout  in  DATA_WIDTH  global read data
tile_addr  out  ADDR_WIDTH  buf_sel*TILE_ROWS + row index
tile_wdata  out  TILE_COLS*DATA_WIDTH  lane j occupies bits [j*DATA_WIDTH +: DATA_WIDTH]
tile_we  out  TILE_COLS  per-lane write enable; all lanes assert together
full_pulse  out  1  one-cycle pulse when the last element is captured
almost_full_pulse  out  1  one-cycle pulse when exactly ALMOST_LEFT elements remain uncaptured
words_written  out  16  running count of elements written this load

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pending reads discarded. Reset mid-load aborts with no further writes.
- FSM: IDLE -> ISSUE on start. ISSUE -> DRAIN after the last read issues. DRAIN -> DONE after the last row write. DONE -> IDLE after one cycle.
- start outside IDLE, including in the DONE cycle, is ignored. start on the cycle after done is accepted.
- ISSUE: global_re=1 for exactly TILE_ROWS*TILE_COLS consecutive cycles, starting the cycle after accept.
- Address order is row-major: base + r*MATRIX_COLS + c. It is produced by a row-base accumulator, not a multiplier, and wraps modulo 2^ADDR_WIDTH.
- Capture: a RD_LATENCY-deep valid/column shift register tracks reads in flight. global_dout is captured RD_LATENCY cycles after its global_re cycle, into the lane for that element's column.
- Row write: in the cycle after column TILE_COLS-1 is captured, tile_we is all-ones for one cycle, with tile_wdata holding the row and tile_addr = buf_sel_latched*TILE_ROWS + r. words_written increments by TILE_COLS on each row write.
- Row r's write may overlap the issue of row r+1's reads; throughput is one element per cycle.
- Latency: done asserts TILE_ROWS*TILE_COLS + RD_LATENCY + 2 cycles after the accepting edge (19 with defaults).
- full_pulse and almost_full_pulse are derived from the captured-element count, each firing once per load. If ALMOST_LEFT = 0 is configured, the two pulses coincide.
- words_written clears on accept and holds its value after done.

Optional Feature:
TILE_CLIP_EN:
- Adds inputs valid_rows (8 bits) and valid_cols (8 bits), latched on accept.
- Elements with r>=valid_rows or c>=valid_cols suppress global_re for their slot. The address still advances, and the lane is written with zero.
- Timing and the row write sequence are unchanged.
- Undefined: ports are absent and every element is read.

Decomposition:
- Package bram_tile_pkg holds the FSM state localparams (IDLE, ISSUE, DRAIN, DONE) and a function for the TILE_ROWS*TILE_COLS element count, with its width via $clog2.
- One sub-module, tile_row_packer: takes the capture valid, column index and data; holds the lane registers; emits the row-write strobe and packed data.

Test Plan:
- Defaults, base=0, buf_sel=0, global_dout = address: reads 0-3, 8-11, 16-19, 24-27. Row writes at tile_addr 0..3 with row0 lanes 0,1,2,3. done at cycle 19; words_written=16.
- buf_sel=1, base=2, RD_LATENCY=2: tile_addr 4..7, row0 lanes 2,3,4,5. done at cycle 20.
- Back-to-back loads: start held high; the second load is accepted the cycle after done, and the DONE-cycle start is ignored.
- base=1020, ADDR_WIDTH=10: addresses wrap to 1020-1023, 4-7, ...; no X on outputs.
- rst_n low at cycle 8: all outputs 0 immediately, no tile_we afterwards; the next start runs a clean load.
- TILE_CLIP_EN, valid_rows=3, valid_cols=2: 6 global reads; lanes 2-3 and row 3 are zero; done still at cycle 19.

Source files
------------

// File: rtl/bram_tile_pkg.sv
// Shared definitions for the BRAM tile loader.
//   - FSM state encodings (IDLE, ISSUE, DRAIN, DONE)
//   - tile_elems():     number of elements in one tile
//   - tile_cnt_width(): width of a counter that can hold the element count
package bram_tile_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic int unsigned tile_elems(input int unsigned rows, input int unsigned cols);
    return rows * cols;
  endfunction

  function automatic int unsigned tile_cnt_width(input int unsigned rows,
                                                 input int unsigned cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/tile_row_packer.sv
// Collects captured elements into per-column lane registers and raises a one-cycle row
// write strobe in the cycle after the last column of a row has been captured.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   cap_valid   an element is being captured this cycle
//   cap_col     column (lane) of the captured element
//   cap_data    element value
//   row_we      row write strobe (one cycle)
//   row_data    packed lanes, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
module tile_row_packer
  import bram_tile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TILE_COLS  = 4,
  parameter int unsigned COL_W      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cap_valid,
  input  logic [COL_W-1:0]                cap_col,
  input  logic [DATA_WIDTH-1:0]           cap_data,
  output logic                            row_we,
  output logic [TILE_COLS*DATA_WIDTH-1:0] row_data
);

  logic [DATA_WIDTH-1:0] lane_q [TILE_COLS];
  logic                  row_we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < TILE_COLS; j++) lane_q[j] <= '0;
      row_we_q <= 1'b0;
    end else begin
      row_we_q <= cap_valid && (cap_col == COL_W'(TILE_COLS - 1));
      for (int j = 0; j < TILE_COLS; j++) begin
        if (cap_valid && (cap_col == COL_W'(j))) lane_q[j] <= cap_data;
      end
    end
  end

  // Lanes are read while the next row's column 0 may be captured at the same edge,
  // so the write cycle always sees the complete previous row.
  always_comb begin
    row_data = '0;
    for (int j = 0; j < TILE_COLS; j++) row_data[j*DATA_WIDTH +: DATA_WIDTH] = lane_q[j];
  end

  assign row_we = row_we_q;

endmodule

// File: rtl/bram_tile_loader.sv
// Streams a TILE_ROWS x TILE_COLS sub-matrix out of a row-major global BRAM (one element
// per cycle) and writes each completed row into TILE_COLS parallel lane BRAMs, in the
// ping-pong half selected at start.
// Optional feature macro: TILE_CLIP_EN (adds valid_rows/valid_cols; clipped elements are
// not read and are written as zero).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, base_addr, buf_sel load request, tile origin, ping-pong half
//   busy, done               load in progress, one-cycle completion pulse
//   global_addr/re/dout      global BRAM read port
//   tile_addr/wdata/we       lane BRAM write port
//   full_pulse               last element captured
//   almost_full_pulse        ALMOST_LEFT elements still to be captured
//   words_written            elements written during the current load
module bram_tile_loader
  import bram_tile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned MATRIX_COLS = 8,
  parameter int unsigned TILE_ROWS   = 4,
  parameter int unsigned TILE_COLS   = 4,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ALMOST_LEFT = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic                            buf_sel,
`ifdef TILE_CLIP_EN
  input  logic [7:0]                      valid_rows,
  input  logic [7:0]                      valid_cols,
`endif
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH-1:0]           global_addr,
  output logic                            global_re,
  input  logic [DATA_WIDTH-1:0]           global_dout,
  output logic [ADDR_WIDTH-1:0]           tile_addr,
  output logic [TILE_COLS*DATA_WIDTH-1:0] tile_wdata,
  output logic [TILE_COLS-1:0]            tile_we,
  output logic                            full_pulse,
  output logic                            almost_full_pulse,
  output logic [15:0]                     words_written
);

  localparam int unsigned NumElems = tile_elems(TILE_ROWS, TILE_COLS);
  localparam int unsigned CntW     = tile_cnt_width(TILE_ROWS, TILE_COLS);
  localparam int unsigned ColW     = (TILE_COLS > 1) ? $clog2(TILE_COLS) : 1;
  localparam int unsigned RowW     = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_base_q;
  logic [ColW-1:0]       iss_col_q;
  logic [CntW-1:0]       iss_cnt_q;
  logic [CntW-1:0]       cap_cnt_q;
  logic [RowW-1:0]       wr_row_q;
  logic                  buf_sel_q;
  logic [15:0]           words_q;

  // Registered read port stage: one slot per issue cycle, clipped or not.
  logic                  re_q, slot_q, clip_q;
  logic [ColW-1:0]       slot_col_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Reads in flight, aligned with the BRAM read latency.
  logic                  pipe_valid_q [RD_LATENCY];
  logic [ColW-1:0]       pipe_col_q   [RD_LATENCY];
  logic                  pipe_clip_q  [RD_LATENCY];

  logic accept, issue, last_issue, last_write, slot_clip;
  logic cap_valid, row_we;
  logic [ColW-1:0]       cap_col;
  logic [DATA_WIDTH-1:0] cap_data;

  assign accept     = (state_q == IDLE) && start;
  assign issue      = (state_q == ISSUE);
  assign last_issue = issue && (iss_cnt_q == CntW'(NumElems - 1));
  assign last_write = row_we && (wr_row_q == RowW'(TILE_ROWS - 1));

`ifdef TILE_CLIP_EN
  logic [7:0]      valid_rows_q, valid_cols_q;
  logic [RowW-1:0] iss_row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_rows_q <= '0;
      valid_cols_q <= '0;
      iss_row_q    <= '0;
    end else if (accept) begin
      valid_rows_q <= valid_rows;
      valid_cols_q <= valid_cols;
      iss_row_q    <= '0;
    end else if (issue && (iss_col_q == ColW'(TILE_COLS - 1))) begin
      iss_row_q <= iss_row_q + 1'b1;
    end
  end

  assign slot_clip = (32'(iss_row_q) >= 32'(valid_rows_q)) ||
                     (32'(iss_col_q) >= 32'(valid_cols_q));
`else
  assign slot_clip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (last_write) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_base_q <= '0;
      iss_col_q  <= '0;
      iss_cnt_q  <= '0;
      cap_cnt_q  <= '0;
      wr_row_q   <= '0;
      buf_sel_q  <= 1'b0;
      words_q    <= '0;
      re_q       <= 1'b0;
      slot_q     <= 1'b0;
      clip_q     <= 1'b0;
      slot_col_q <= '0;
      addr_q     <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_col_q[i]   <= '0;
        pipe_clip_q[i]  <= 1'b0;
      end
    end else begin
      state_q <= state_d;

      if (accept) begin
        row_base_q <= base_addr;
        iss_col_q  <= '0;
        iss_cnt_q  <= '0;
        cap_cnt_q  <= '0;
        wr_row_q   <= '0;
        buf_sel_q  <= buf_sel;
        words_q    <= '0;
      end else begin
        if (issue) begin
          iss_cnt_q <= iss_cnt_q + 1'b1;
          if (iss_col_q == ColW'(TILE_COLS - 1)) begin
            iss_col_q  <= '0;
            row_base_q <= row_base_q + ADDR_WIDTH'(MATRIX_COLS);  // wraps modulo 2^ADDR_WIDTH
          end else begin
            iss_col_q <= iss_col_q + 1'b1;
          end
        end
        if (cap_valid) cap_cnt_q <= cap_cnt_q + 1'b1;
        if (row_we) begin
          wr_row_q <= wr_row_q + 1'b1;
          words_q  <= words_q + 16'(TILE_COLS);
        end
      end

      // A clipped slot still occupies its cycle so timing matches an unclipped load.
      re_q       <= issue && !slot_clip;
      slot_q     <= issue;
      clip_q     <= issue && slot_clip;
      slot_col_q <= iss_col_q;
      if (issue) addr_q <= row_base_q + ADDR_WIDTH'(iss_col_q);

      pipe_valid_q[0] <= slot_q;
      pipe_col_q[0]   <= slot_col_q;
      pipe_clip_q[0]  <= clip_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_col_q[i]   <= pipe_col_q[i-1];
        pipe_clip_q[i]  <= pipe_clip_q[i-1];
      end
    end
  end

  assign cap_valid = pipe_valid_q[RD_LATENCY-1];
  assign cap_col   = pipe_col_q[RD_LATENCY-1];
  assign cap_data  = pipe_clip_q[RD_LATENCY-1] ? '0 : global_dout;

  tile_row_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .TILE_COLS (TILE_COLS),
    .COL_W     (ColW)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_valid(cap_valid),
    .cap_col  (cap_col),
    .cap_data (cap_data),
    .row_we   (row_we),
    .row_data (tile_wdata)
  );

  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign global_addr       = addr_q;
  assign global_re         = re_q;
  assign tile_we           = {TILE_COLS{row_we}};
  assign tile_addr         = (buf_sel_q ? ADDR_WIDTH'(TILE_ROWS) : '0) + ADDR_WIDTH'(wr_row_q);
  assign full_pulse        = cap_valid && (cap_cnt_q == CntW'(NumElems - 1));
  assign almost_full_pulse = cap_valid && (cap_cnt_q == CntW'(NumElems - ALMOST_LEFT - 1));
  assign words_written     = words_q;

endmodule
